// File: rtl/tx_block.sv
// 8N1 serial transmitter with a one-entry holding register and load/ready handshake.
// Each frame is a start bit, eight data bits LSB-first and a stop bit, each held BIT_PERIOD clocks.
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overrun_error
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [7:0] LAST_CNT = 8'(BIT_PERIOD - 1);

  state_e     state_q, state_d;
  logic [7:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       overrun_q, overrun_d;
  logic       serial_q, serial_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       bit_end;

  assign bit_end = (clk_cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q | (tx_load & ~ready_q);

    // An accept needs an empty holder and a transfer needs a full one, so they never collide.
    if (tx_load && ready_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          clk_cnt_d    = 8'd0;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = 8'd0;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = 8'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = 8'd0;
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so the registered copies line up with the FSM.
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (clk_cnt_d == LAST_CNT);
    ready_d = ~hold_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= 8'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      serial_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign tx_ready      = ready_q;
  assign serial_out    = serial_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block: a frame-queue reference model under random loads,
// hand-written multi-cycle sequences, and a per-clock vector table on a BIT_PERIOD=2 instance.
`timescale 1ns/1ps
module tb_tx_block;

  localparam int BP  = 10;
  localparam int BP2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready, serial_out, tx_busy, tx_done, overrun_error;
  logic [7:0] tx_data2;
  logic       tx_load2;
  logic       tx_ready2, serial_out2, tx_busy2, tx_done2, overrun_error2;

  int total = 0;
  int bad   = 0;

  always #1.25 clk = ~clk;

  tx_block #(.BIT_PERIOD(BP)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .overrun_error(overrun_error)
  );

  tx_block #(.BIT_PERIOD(BP2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_load(tx_load2),
    .tx_ready(tx_ready2), .serial_out(serial_out2), .tx_busy(tx_busy2),
    .tx_done(tx_done2), .overrun_error(overrun_error2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of per-clock line values, refilled one whole frame at a time.
  typedef struct packed {
    logic s;
    logic b;
    logic d;
  } line_t;

  line_t      line_q[$];
  logic       m_full;
  logic [7:0] m_hold;
  logic       m_ovr;
  logic [4:0] m_exp;

  task automatic model_reset();
    line_q.delete();
    m_full = 1'b0;
    m_hold = 8'h00;
    m_ovr  = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [7:0] d);
    logic  was_empty;
    line_t e;
    was_empty = ~m_full;
    if (line_q.size() == 0 && m_full) begin
      for (int c = 0; c < 10 * BP; c++) begin
        int b;
        b = c / BP;
        e.s = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_hold[b-1];
        e.b = 1'b1;
        e.d = (c == 10 * BP - 1);
        line_q.push_back(e);
      end
      m_full = 1'b0;
    end
    if (line_q.size() > 0) e = line_q.pop_front();
    else e = '{s: 1'b1, b: 1'b0, d: 1'b0};
    if (ld) begin
      if (was_empty) begin
        m_hold = d;
        m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_exp = {e.s, e.b, e.d, ~m_full, m_ovr};
  endtask

  // Observation log for the hand-written sequences; index k = outputs after edge k.
  int   cyc;
  logic obs_s [0:4095];
  logic obs_b [0:4095];
  logic obs_d [0:4095];
  logic obs_r [0:4095];
  logic obs_o [0:4095];

  task automatic cycle(input logic ld, input logic [7:0] d);
    tx_load = ld;
    tx_data = d;
    @(posedge clk);
    model_step(ld, d);
    @(negedge clk);
    if (cyc < 4096) begin
      obs_s[cyc] = serial_out;
      obs_b[cyc] = tx_busy;
      obs_d[cyc] = tx_done;
      obs_r[cyc] = tx_ready;
      obs_o[cyc] = overrun_error;
    end
    check($sformatf("model cyc%0d {ser,busy,done,rdy,ovr}", cyc),
          32'({serial_out, tx_busy, tx_done, tx_ready, overrun_error}), 32'(m_exp));
    cyc++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_load  = 1'b0;
    tx_load2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  function automatic logic [7:0] decode(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = obs_s[s + BP * (i + 1) + BP / 2];
    return b;
  endfunction

  function automatic logic framed(input int s);
    return (obs_s[s + BP / 2] == 1'b0) && (obs_s[s + 9 * BP + BP / 2] == 1'b1);
  endfunction

  typedef struct packed {
    logic       ld;
    logic [7:0] d;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n_done;
    int done_at;

    // BIT_PERIOD=2, load 0x00: {serial,busy,done,ready,overrun} after each edge.
    tbl[0] = '{ld: 1'b1, d: 8'h00, exp: 5'b10000};
    for (int i = 1; i <= 18; i++) tbl[i] = '{ld: 1'b0, d: 8'h00, exp: 5'b01010};
    tbl[19] = '{ld: 1'b0, d: 8'h00, exp: 5'b11010};
    tbl[20] = '{ld: 1'b0, d: 8'h00, exp: 5'b11110};
    tbl[21] = '{ld: 1'b0, d: 8'h00, exp: 5'b10010};

    rst      = 1'b1;
    tx_load  = 1'b0;
    tx_data  = 8'h00;
    tx_load2 = 1'b0;
    tx_data2 = 8'h00;
    model_reset();
    cyc = 0;
    #3;
    check("reset serial_out", 32'(serial_out), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    check("reset overrun", 32'(overrun_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame 0xD5.
    do_reset();
    for (int k = 0; k < 120; k++) cycle(k == 0, 8'hD5);
    n_done  = 0;
    done_at = -1;
    for (int k = 0; k < 120; k++) if (obs_d[k]) begin n_done++; done_at = k; end
    check("d5 decoded byte", 32'(decode(1)), 32'hD5);
    check("d5 framing", 32'(framed(1)), 32'd1);
    check("d5 done count", 32'(n_done), 32'd1);
    check("d5 done clock", 32'(done_at), 32'd100);
    check("d5 busy at 100", 32'(obs_b[100]), 32'd1);
    check("d5 busy after", 32'(obs_b[101]), 32'd0);

    // Back-to-back 0xA5 then 0x3C.
    do_reset();
    for (int k = 0; k < 220; k++) cycle(k == 0 || k == 5, (k == 0) ? 8'hA5 : 8'h3C);
    check("b2b first byte", 32'(decode(1)), 32'hA5);
    check("b2b second byte", 32'(decode(101)), 32'h3C);
    check("b2b second start", 32'(obs_s[101]), 32'd0);
    check("b2b ready before", 32'(obs_r[100]), 32'd0);
    check("b2b ready at start", 32'(obs_r[101]), 32'd1);
    for (int k = 1; k <= 200; k++) if (!obs_b[k]) check($sformatf("b2b busy gap %0d", k), 32'(obs_b[k]), 32'd1);
    check("b2b idle after", 32'(obs_b[201]), 32'd0);

    // Overrun: 0x11, 0x22 buffered, 0x33 rejected.
    do_reset();
    for (int k = 0; k < 240; k++)
      cycle(k == 0 || k == 5 || k == 10, (k == 0) ? 8'h11 : (k == 5) ? 8'h22 : 8'h33);
    check("ovr clear before", 32'(obs_o[9]), 32'd0);
    check("ovr set", 32'(obs_o[10]), 32'd1);
    check("ovr first byte", 32'(decode(1)), 32'h11);
    check("ovr second byte", 32'(decode(101)), 32'h22);
    check("ovr no third frame", 32'(obs_b[201]), 32'd0);
    check("ovr sticky", 32'(obs_o[239]), 32'd1);

    // Asynchronous reset in the middle of DATA.
    do_reset();
    for (int k = 0; k < 40; k++) cycle(k == 0 || k == 3, (k == 0) ? 8'h00 : 8'h77);
    rst = 1'b1;
    #0.2;
    check("async rst serial_out", 32'(serial_out), 32'd1);
    check("async rst tx_busy", 32'(tx_busy), 32'd0);
    check("async rst tx_ready", 32'(tx_ready), 32'd1);
    check("async rst overrun", 32'(overrun_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    for (int k = 0; k < 30; k++) cycle(1'b0, 8'h00);
    check("after rst stays idle", 32'(tx_busy), 32'd0);

    // Randomized loads at several densities, each phase from reset.
    for (int p = 0; p < 3; p++) begin
      int pct;
      pct = (p == 0) ? 1 : (p == 1) ? 3 : 40;
      do_reset();
      for (int k = 0; k < 1500; k++)
        cycle($urandom_range(0, 99) < pct, 8'($urandom));
    end

    // BIT_PERIOD=2 vector table.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      tx_load2 = tbl[i].ld;
      tx_data2 = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp2 row%0d {ser,busy,done,rdy,ovr}", i),
            32'({serial_out2, tx_busy2, tx_done2, tx_ready2, overrun_error2}), 32'(tbl[i].exp));
    end
    tx_load2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
